// File: rtl/mac_seq_pkg.sv
// Shared encodings for the MAC job sequencer: multiplier modes and FSM states.
package mac_seq_pkg;

  localparam logic [1:0] MODE_16X16   = 2'b00;
  localparam logic [1:0] MODE_SUM_8X8 = 2'b01;
  localparam logic [1:0] MODE_SUM_4X4 = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic mode_legal(input logic [1:0] m);
    return (m == MODE_16X16) || (m == MODE_SUM_8X8) || (m == MODE_SUM_4X4);
  endfunction

endpackage

// File: rtl/mac_seq_valid_pipe.sv
// Valid-token shift register tracking products in flight through the multiplier.
// DEPTH must be at least 2.
module mac_seq_valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  output logic o_last,
  output logic o_empty
);

  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[DEPTH-2:0], i_valid};
    end
  end

  assign o_last  = r_pipe[DEPTH-1];
  assign o_empty = ~|r_pipe;

endmodule

// File: rtl/mac_job_sequencer.sv
// Job-level controller feeding a precision-configurable multiplier and accumulating result_0.
// Optional saturating accumulation and res_sat port: define MAC_JOB_SEQ_SAT_EN.
module mac_job_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned MULT_LAT = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ACC_W    = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_a_sign,
  input  logic             cfg_b_sign,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic [1:0]       mul_mode,
  output logic             mul_a_sign,
  output logic             mul_b_sign,
  input  logic [31:0]      mul_result_0,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_err,
  output logic             busy
`ifdef MAC_JOB_SEQ_SAT_EN
  ,
  output logic             res_sat
`endif
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_issued;
  logic [ACC_W-1:0] r_acc;
  logic             r_err;

  logic             w_cfg_hs;
  logic             w_op_hs;
  logic [CNT_W-1:0] w_issued_nxt;
  logic             w_pipe_last;
  logic             w_pipe_empty;
  logic             w_signed;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_acc_nxt;

  assign cfg_ready    = (r_state == ST_IDLE);
  assign op_ready     = (r_state == ST_RUN) && (r_issued < r_len);
  assign res_valid    = (r_state == ST_DONE);
  assign busy         = (r_state != ST_IDLE);
  assign res_data     = r_acc;
  assign res_err      = r_err;
  assign w_cfg_hs     = cfg_valid & cfg_ready;
  assign w_op_hs      = op_valid & op_ready;
  assign w_issued_nxt = r_issued + CNT_W'(1);
  assign w_signed     = mul_a_sign | mul_b_sign;
  assign w_ext        = w_signed ? {{(ACC_W-32){mul_result_0[31]}}, mul_result_0}
                                 : {{(ACC_W-32){1'b0}}, mul_result_0};

  mac_seq_valid_pipe #(
    .DEPTH (MULT_LAT + 1)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_op_hs),
    .o_last  (w_pipe_last),
    .o_empty (w_pipe_empty)
  );

`ifdef MAC_JOB_SEQ_SAT_EN
  logic [ACC_W:0] w_sum;
  logic           w_ovf;
  logic           r_sat;

  assign w_sum   = {1'b0, r_acc} + {1'b0, w_ext};
  assign res_sat = r_sat;

  // Signed overflow: addends agree in sign but the sum does not; unsigned: carry out.
  always_comb begin
    w_ovf     = 1'b0;
    w_acc_nxt = w_sum[ACC_W-1:0];
    if (w_signed) begin
      if ((r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1])) begin
        w_ovf     = 1'b1;
        w_acc_nxt = r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (w_sum[ACC_W]) begin
      w_ovf     = 1'b1;
      w_acc_nxt = '1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat <= 1'b0;
    end else if (w_cfg_hs) begin
      r_sat <= 1'b0;
    end else if (w_pipe_last && w_ovf) begin
      r_sat <= 1'b1;
    end
  end
`else
  assign w_acc_nxt = r_acc + w_ext;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_issued   <= '0;
      r_acc      <= '0;
      r_err      <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_mode   <= '0;
      mul_a_sign <= 1'b0;
      mul_b_sign <= 1'b0;
    end else begin
      // The pipe is empty in IDLE, so accumulation never races the clear below.
      if (w_pipe_last) begin
        r_acc <= w_acc_nxt;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_cfg_hs) begin
            mul_mode   <= cfg_mode;
            mul_a_sign <= cfg_a_sign;
            mul_b_sign <= cfg_b_sign;
            r_len      <= cfg_len;
            r_issued   <= '0;
            r_acc      <= '0;
            r_err      <= 1'b0;
            if (!mode_legal(cfg_mode)) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else if (cfg_len == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_op_hs) begin
            mul_a    <= op_a;
            mul_b    <= op_b;
            r_issued <= w_issued_nxt;
            if (w_issued_nxt == r_len) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          if (res_ready) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
